alu_result_collector: RTL and testbench
=======================================

// Module: alu_result_collector
// PURPOSE
//  Downstream stage of the 16-bit ALU top. Captures whichever unit result (arith/logic/cmp/shift) is flagged
//  valid each cycle and tags it with its source unit. Buffers it in a small FIFO and presents one result
//  stream to the consumer via a valid/ready handshake. The ALU has no backpressure, so results arriving
//  while the FIFO is full are dropped and counted.
// PARAMETERS
//  Data_In_Width  16  ALU operand width; result word is 2*Data_In_Width
//  FIFO_Depth     4   result buffer entries; power of two, >=2
//  Cnt_Width      8   width of drop counter
// PORTS
//  CLK         in   1          clock, all state on rising edge
//  RST         in   1          synchronous, active-high reset
//  Arith_OUT   in   2*DW       arithmetic unit result
//  Arith_Flag  in   1          arith result valid this cycle
//  Logic_OUT   in   DW         logic unit result
//  Logic_Flag  in   1          logic result valid
//  CMP_OUT     in   2          compare result
//  CMP_Flag    in   1          compare result valid
//  Shift_OUT   in   DW         shift unit result
//  Shift_Flag  in   1          shift result valid
//  RES_READY   in   1          consumer accepts head entry
//  ERR_CLR     in   1          clears ERR_MULTI and DROP_CNT
//  RES_DATA    out  2*DW       head result, zero-extended
//  RES_SRC     out  2          source unit: 0 arith, 1 logic, 2 cmp, 3 shift
//  RES_ZERO    out  1          RES_DATA == 0
//  RES_VALID   out  1          FIFO non-empty
//  FIFO_FULL   out  1          FIFO holds FIFO_Depth entries
//  DROP_CNT    out  Cnt_Width  results lost while full; saturates at all-ones
//  ERR_MULTI   out  1          sticky: more than one flag high in one cycle
// BEHAVIOUR
//  - Reset: FIFO empty, RES_VALID=0, RES_DATA=0, RES_SRC=0, RES_ZERO=1, FIFO_FULL=0, DROP_CNT=0, ERR_MULTI=0.
//  - Push: any flag high -> push=1. Selection priority is arith > logic > cmp > shift.
//    Logic/shift/cmp results are zero-extended to 2*DW. RES_ZERO is computed at push and stored with the entry.
//  - Multi-hot flags: the highest-priority unit is pushed, the others are discarded, ERR_MULTI sets.
//  - Latency: a flag in cycle N gives RES_VALID=1 with that data in cycle N+1. No combinational bypass.
//  - Pop: RES_VALID & RES_READY at the clock edge. The head advances and outputs update the next cycle.
//  - RES_DATA/RES_SRC/RES_ZERO are the head entry, stable while RES_VALID & !RES_READY.
//    When empty they are X-free and hold their last value.
//  - Full, push, no pop: entry dropped, DROP_CNT+1 (saturating), FIFO unchanged.
//  - Full, push and pop in the same cycle: pop frees a slot, push accepted, count unchanged, nothing dropped.
//  - Empty, pop requested: ignored (RES_VALID=0). Empty, push: count becomes 1.
//  - Pointers wrap modulo FIFO_Depth. Occupancy counter is log2(FIFO_Depth)+1 bits.
//  - ERR_CLR: clears DROP_CNT and ERR_MULTI next cycle. On a simultaneous drop or multi-hot event, the clear wins.
//  - RST mid-operation: all buffered results discarded, state returns to reset values next edge.
// STRUCTURE
//  - Shared include alu_defs.vh: unit-ID localparams SRC_ARITH=2'd0, SRC_LOGIC=2'd1, SRC_CMP=2'd2,
//    SRC_SHIFT=2'd3, plus the default widths. Also used by the decoder and the ALU top.
//  - One sub-module: alu_sync_fifo (param WIDTH, DEPTH; push/pop/full/empty; sync active-high reset).
//    The entry is {zero, src, data} = 2*DW+3 bits.
//  - Top level holds the priority select, zero-extend, drop/error logic and counters.
// TESTING
//  1 Reset, then Arith_Flag=1, Arith_OUT=32'h0001_FFFE, RES_READY=1 -> next cycle RES_VALID=1,
//    RES_DATA=32'h0001_FFFE, RES_SRC=0, RES_ZERO=0; the following cycle RES_VALID=0.
//  2 Logic_Flag=1, Logic_OUT=16'h0000 -> RES_DATA=0, RES_SRC=1, RES_ZERO=1.
//    CMP_Flag=1, CMP_OUT=2'b10 -> RES_DATA=32'h2, RES_SRC=2.
//  3 RES_READY=0, push 6 shift results 1..6 (Depth=4) -> FIFO_FULL=1, DROP_CNT=2.
//    Then RES_READY=1 drains 1,2,3,4 in order, SRC=3.
//  4 FIFO full, one push with RES_READY=1 in the same cycle -> DROP_CNT unchanged, FIFO_FULL stays 1,
//    the new entry is last out.
//  5 Arith_Flag=Shift_Flag=1 in one cycle -> one entry, SRC=0, ERR_MULTI=1.
//    ERR_CLR pulse -> ERR_MULTI=0, DROP_CNT=0.
//  6 Three entries buffered, RST=1 for one cycle -> RES_VALID=0, DROP_CNT=0, RES_ZERO=1.
//    The next push appears one cycle later.

Source files
------------

// File: rtl/alu_result_collector_pkg.sv
// Shared definitions for the ALU result collector.
// Holds the source-unit identifiers that tag every buffered result, the
// default widths, and a helper that flags more than one unit reporting in the
// same cycle.
package alu_result_collector_pkg;

  localparam int DEF_DATA_IN_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH    = 4;
  localparam int DEF_CNT_WIDTH     = 8;

  // Source-unit tag carried with each result.
  typedef enum logic [1:0] {
    SRC_ARITH = 2'd0,
    SRC_LOGIC = 2'd1,
    SRC_CMP   = 2'd2,
    SRC_SHIFT = 2'd3
  } src_e;

  // True when two or more bits of the flag vector are set. Clearing the
  // lowest set bit leaves a non-zero value only if another bit was set.
  function automatic logic multi_hot(input logic [3:0] flags);
    return (flags & (flags - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/alu_sync_fifo.sv
// Synchronous single-clock FIFO used to buffer tagged ALU results.
// Ports:
//   clk_i    clock, all state on the rising edge
//   rst_i    synchronous active-high reset (pointers and occupancy only)
//   push_i   write wdata_i; ignored when full unless a pop frees a slot
//   wdata_i  entry to write
//   pop_i    advance the head; ignored when empty
//   rdata_o  head entry (only meaningful while empty_o is low)
//   full_o   DEPTH entries held
//   empty_o  no entries held
module alu_sync_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  logic push_eff;
  logic pop_eff;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // still accepted when the head is leaving.
  assign pop_eff  = pop_i & ~empty_o;
  assign push_eff = push_i & (~full_o | pop_eff);

  assign rdata_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_eff) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_eff)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_result_collector.sv
// ALU result collector: captures the unit result flagged valid each cycle,
// tags it with its source unit, buffers it and presents a single valid/ready
// result stream. The ALU cannot be stalled, so results arriving while the
// buffer is full are dropped and counted.
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   Arith_OUT/Arith_Flag          arithmetic result (2*DW) and its valid
//   Logic_OUT/Logic_Flag          logic result (DW) and its valid
//   CMP_OUT/CMP_Flag              compare result (2 bits) and its valid
//   Shift_OUT/Shift_Flag          shift result (DW) and its valid
//   RES_READY                     consumer accepts the head entry
//   ERR_CLR                       clears DROP_CNT and ERR_MULTI
//   RES_DATA/RES_SRC/RES_ZERO     head entry: data, source tag, data==0
//   RES_VALID                     buffer non-empty
//   FIFO_FULL                     buffer holds FIFO_Depth entries
//   DROP_CNT                      saturating count of dropped results
//   ERR_MULTI                     sticky: several flags high in one cycle
module alu_result_collector
  import alu_result_collector_pkg::*;
#(
  parameter int Data_In_Width = DEF_DATA_IN_WIDTH,
  parameter int FIFO_Depth    = DEF_FIFO_DEPTH,
  parameter int Cnt_Width     = DEF_CNT_WIDTH
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [2*Data_In_Width-1:0] Arith_OUT,
  input  logic                       Arith_Flag,
  input  logic [Data_In_Width-1:0]   Logic_OUT,
  input  logic                       Logic_Flag,
  input  logic [1:0]                 CMP_OUT,
  input  logic                       CMP_Flag,
  input  logic [Data_In_Width-1:0]   Shift_OUT,
  input  logic                       Shift_Flag,
  input  logic                       RES_READY,
  input  logic                       ERR_CLR,
  output logic [2*Data_In_Width-1:0] RES_DATA,
  output logic [1:0]                 RES_SRC,
  output logic                       RES_ZERO,
  output logic                       RES_VALID,
  output logic                       FIFO_FULL,
  output logic [Cnt_Width-1:0]       DROP_CNT,
  output logic                       ERR_MULTI
);

  localparam int RW = 2 * Data_In_Width;
  // Entry layout: {zero, src, data}
  localparam int EW = RW + 3;

  function automatic logic [Cnt_Width-1:0] sat_inc(input logic [Cnt_Width-1:0] v);
    return (&v) ? v : v + Cnt_Width'(1);
  endfunction

  logic [3:0]    flags;
  logic          any_flag;
  src_e          sel_src;
  logic [RW-1:0] sel_data;
  logic          sel_zero;
  logic [EW-1:0] push_entry;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [EW-1:0] fifo_rdata;
  logic          drop;

  logic [EW-1:0]        hold_q, hold_d;
  logic [EW-1:0]        head_entry;
  logic [Cnt_Width-1:0] drop_cnt_q, drop_cnt_d;
  logic                 err_multi_q, err_multi_d;

  assign flags    = {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
  assign any_flag = |flags;

  // Fixed priority arith > logic > cmp > shift; narrower results are
  // zero-extended to the full result width.
  always_comb begin
    sel_src  = SRC_ARITH;
    sel_data = '0;
    if (Arith_Flag) begin
      sel_src  = SRC_ARITH;
      sel_data = Arith_OUT;
    end else if (Logic_Flag) begin
      sel_src  = SRC_LOGIC;
      sel_data = {{Data_In_Width{1'b0}}, Logic_OUT};
    end else if (CMP_Flag) begin
      sel_src  = SRC_CMP;
      sel_data = {{(RW-2){1'b0}}, CMP_OUT};
    end else if (Shift_Flag) begin
      sel_src  = SRC_SHIFT;
      sel_data = {{Data_In_Width{1'b0}}, Shift_OUT};
    end
  end

  // Zero flag is computed once at capture so the output path is a plain mux.
  assign sel_zero   = (sel_data == '0);
  assign push_entry = {sel_zero, sel_src, sel_data};

  assign fifo_pop  = ~fifo_empty & RES_READY;
  assign fifo_push = any_flag & (~fifo_full | fifo_pop);
  assign drop      = any_flag & fifo_full & ~fifo_pop;

  alu_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_Depth)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (fifo_push),
    .wdata_i (push_entry),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // hold_q remembers the last entry handed to the consumer so the outputs
  // keep a defined, unchanged value while the buffer is empty.
  assign hold_d     = fifo_pop ? fifo_rdata : hold_q;
  assign head_entry = fifo_empty ? hold_q : fifo_rdata;

  // Clear takes precedence over a drop or multi-hot event in the same cycle.
  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    err_multi_d = err_multi_q;
    if (ERR_CLR) begin
      drop_cnt_d  = '0;
      err_multi_d = 1'b0;
    end else begin
      if (drop)            drop_cnt_d  = sat_inc(drop_cnt_q);
      if (multi_hot(flags)) err_multi_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_q      <= {1'b1, SRC_ARITH, {RW{1'b0}}};
      drop_cnt_q  <= '0;
      err_multi_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      drop_cnt_q  <= drop_cnt_d;
      err_multi_q <= err_multi_d;
    end
  end

  assign RES_DATA  = head_entry[RW-1:0];
  assign RES_SRC   = head_entry[RW+1:RW];
  assign RES_ZERO  = head_entry[EW-1];
  assign RES_VALID = ~fifo_empty;
  assign FIFO_FULL = fifo_full;
  assign DROP_CNT  = drop_cnt_q;
  assign ERR_MULTI = err_multi_q;

endmodule

// File: tb/tb_alu_result_collector.sv
module tb_alu_result_collector;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic [31:0]   Arith_OUT;
  logic          Arith_Flag;
  logic [15:0]   Logic_OUT;
  logic          Logic_Flag;
  logic [1:0]    CMP_OUT;
  logic          CMP_Flag;
  logic [15:0]   Shift_OUT;
  logic          Shift_Flag;
  logic          RES_READY;
  logic          ERR_CLR;
  logic [31:0]   RES_DATA;
  logic [1:0]    RES_SRC;
  logic          RES_ZERO;
  logic          RES_VALID;
  logic          FIFO_FULL;
  logic [CW-1:0] DROP_CNT;
  logic          ERR_MULTI;

  alu_result_collector #(
    .Data_In_Width (DW),
    .FIFO_Depth    (DEPTH),
    .Cnt_Width     (CW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Arith_OUT  (Arith_OUT),
    .Arith_Flag (Arith_Flag),
    .Logic_OUT  (Logic_OUT),
    .Logic_Flag (Logic_Flag),
    .CMP_OUT    (CMP_OUT),
    .CMP_Flag   (CMP_Flag),
    .Shift_OUT  (Shift_OUT),
    .Shift_Flag (Shift_Flag),
    .RES_READY  (RES_READY),
    .ERR_CLR    (ERR_CLR),
    .RES_DATA   (RES_DATA),
    .RES_SRC    (RES_SRC),
    .RES_ZERO   (RES_ZERO),
    .RES_VALID  (RES_VALID),
    .FIFO_FULL  (FIFO_FULL),
    .DROP_CNT   (DROP_CNT),
    .ERR_MULTI  (ERR_MULTI)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  src;
    logic        zero;
  } exp_t;

  // Reference state: queue of results the consumer should receive, and the
  // status the DUT should show after the most recent clock edge.
  exp_t sb[$];
  int   model_cnt;
  int   model_drop;
  bit   model_err;
  exp_t last;
  bit   chk_en = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, against the reference
  // state for the current cycle.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("RES_VALID", 32'(RES_VALID), 32'(model_cnt > 0));
      chk("FIFO_FULL", 32'(FIFO_FULL), 32'(model_cnt == DEPTH));
      chk("DROP_CNT",  32'(DROP_CNT),  32'(model_drop));
      chk("ERR_MULTI", 32'(ERR_MULTI), 32'(model_err));
      if (RES_VALID) begin
        if (sb.size() == 0) begin
          chk("scoreboard_nonempty", 32'(sb.size()), 32'd1);
        end else begin
          chk("RES_DATA", RES_DATA,       sb[0].data);
          chk("RES_SRC",  32'(RES_SRC),   32'(sb[0].src));
          chk("RES_ZERO", 32'(RES_ZERO),  32'(sb[0].zero));
          if (RES_READY) begin
            last = sb[0];
            void'(sb.pop_front());
          end
        end
      end else begin
        chk("HOLD_DATA", RES_DATA,      last.data);
        chk("HOLD_SRC",  32'(RES_SRC),  32'(last.src));
        chk("HOLD_ZERO", 32'(RES_ZERO), 32'(last.zero));
      end
    end
  end

  task automatic clear_inputs();
    Arith_Flag = 0; Logic_Flag = 0; CMP_Flag = 0; Shift_Flag = 0;
    Arith_OUT = '0; Logic_OUT = '0; CMP_OUT = '0; Shift_OUT = '0;
    ERR_CLR = 0;
  endtask

  // Advance one cycle with the currently driven inputs and apply the
  // behavioural rules to predict the effect of the coming clock edge.
  task automatic step();
    bit   pop_p;
    bit   drop_ev;
    int   nflags;
    exp_t e;
    @(negedge CLK); #1;
    if (RST) begin
      sb.delete();
      model_cnt  = 0;
      model_drop = 0;
      model_err  = 0;
      last.data  = '0;
      last.src   = 2'd0;
      last.zero  = 1'b1;
    end else begin
      pop_p   = (model_cnt > 0) && RES_READY;
      drop_ev = 0;
      nflags  = int'(Arith_Flag) + int'(Logic_Flag) + int'(CMP_Flag) + int'(Shift_Flag);
      if (pop_p) model_cnt--;
      if (nflags > 0) begin
        if (Arith_Flag) begin
          e.data = Arith_OUT; e.src = 2'd0;
        end else if (Logic_Flag) begin
          e.data = 32'(Logic_OUT); e.src = 2'd1;
        end else if (CMP_Flag) begin
          e.data = 32'(CMP_OUT); e.src = 2'd2;
        end else begin
          e.data = 32'(Shift_OUT); e.src = 2'd3;
        end
        e.zero = (e.data == 0);
        if (model_cnt < DEPTH) begin
          sb.push_back(e);
          model_cnt++;
        end else begin
          drop_ev = 1;
        end
      end
      if (ERR_CLR) begin
        model_drop = 0;
        model_err  = 0;
      end else begin
        if (nflags > 1) model_err = 1;
        if (drop_ev && model_drop < (1 << CW) - 1) model_drop++;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 1;
    step();
    RST = 0;
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) begin
      clear_inputs();
      RES_READY = rdy;
      step();
    end
  endtask

  task automatic push_shift(input logic [15:0] v, input bit rdy);
    clear_inputs();
    Shift_Flag = 1; Shift_OUT = v; RES_READY = rdy;
    step();
  endtask

  initial begin
    RST = 1; RES_READY = 0;
    clear_inputs();
    @(posedge CLK); #1;
    do_reset();
    chk_en = 1;
    idle(1, 2);

    // Arithmetic result with immediate consumption.
    clear_inputs(); Arith_Flag = 1; Arith_OUT = 32'h0001_FFFE; RES_READY = 1; step();
    idle(1, 2);

    // Zero logic result, then a compare result.
    clear_inputs(); Logic_Flag = 1; Logic_OUT = 16'h0000; step();
    clear_inputs(); CMP_Flag = 1; CMP_OUT = 2'b10; step();
    idle(1, 3);

    // Overfill with the consumer stalled, then drain.
    for (int i = 1; i <= 6; i++) push_shift(16'(i), 0);
    idle(0, 1);
    idle(1, 5);

    // Full buffer, push coinciding with a pop.
    for (int i = 11; i <= 14; i++) push_shift(16'(i), 0);
    push_shift(16'h00AA, 1);
    idle(1, 6);

    // Multi-hot flags, then clear of the sticky error and drop count.
    clear_inputs(); Arith_Flag = 1; Arith_OUT = 32'h1234_5678;
    Shift_Flag = 1; Shift_OUT = 16'h9ABC; step();
    idle(1, 2);
    clear_inputs(); ERR_CLR = 1; step();
    idle(1, 2);

    // Reset with entries buffered, then a fresh push.
    for (int i = 21; i <= 23; i++) push_shift(16'(i), 0);
    do_reset();
    idle(0, 1);
    clear_inputs(); Logic_Flag = 1; Logic_OUT = 16'h5A5A; RES_READY = 0; step();
    idle(1, 3);

    // Drop counter saturation, and clear winning over a simultaneous drop.
    for (int i = 0; i < 4 + 260; i++) push_shift(16'(i), 0);
    clear_inputs(); Shift_Flag = 1; Shift_OUT = 16'h7777; ERR_CLR = 1; RES_READY = 0; step();
    idle(1, 6);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      clear_inputs();
      Arith_Flag = ($urandom_range(0, 9) < 2);
      Logic_Flag = ($urandom_range(0, 9) < 2);
      CMP_Flag   = ($urandom_range(0, 9) < 2);
      Shift_Flag = ($urandom_range(0, 9) < 2);
      Arith_OUT  = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
      Logic_OUT  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      CMP_OUT    = 2'($urandom);
      Shift_OUT  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      RES_READY  = ($urandom_range(0, 9) < 6);
      ERR_CLR    = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step();
      end
    end
    idle(1, 8);

    chk("final_occupancy", 32'(sb.size()), 32'(model_cnt));
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
